la_oapipe: RTL and testbench



---
 rtl/la_oapipe_pkg.sv | 61 ++++++
 rtl/la_oapipe_stage.sv | 46 ++++
 rtl/la_oapipe.sv | 135 +++++++++++++
 tb/tb_la_oapipe.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_oapipe_pkg.sv
// -----------------------------------------------------------------------------
// la_oapipe_pkg
//
// Shared definitions for the la_oapipe or-and pipeline:
//   - function-select encodings for the four reductions
//   - reduce_bit(): the per-bit or-and / and-or evaluation, given the OR and
//     AND of the a-terms and b-terms at one bit position
//   - col_or() / col_and(): column reductions over a packed term vector
//
// Callers reduce each term group down to "any" (OR) and "all" (AND) per bit
// first. The per-bit function is then identical for every NA/NB/W choice.
// -----------------------------------------------------------------------------
package la_oapipe_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t OA  = 2'd0;  // OR(a) & OR(b)
  localparam mode_t OAI = 2'd1;  // ~(OR(a) & OR(b))
  localparam mode_t AO  = 2'd2;  // AND(a) | AND(b)
  localparam mode_t AOI = 2'd3;  // ~(AND(a) | AND(b))

  // Per-bit reduction. any_x / all_x are the OR / AND of the x-terms at this
  // bit position.
  function automatic logic reduce_bit(input mode_t mode,
                                      input logic  any_a,
                                      input logic  all_a,
                                      input logic  any_b,
                                      input logic  all_b);
    logic r;
    case (mode)
      OA:      r = any_a & any_b;
      OAI:     r = ~(any_a & any_b);
      AO:      r = all_a | all_b;
      default: r = ~(all_a | all_b);
    endcase
    return r;
  endfunction

  // Column OR of term bit k in a packed vector of n terms, each w bits wide.
  function automatic logic col_or(input logic [255:0] terms,
                                  input int           n,
                                  input int           w,
                                  input int           k);
    logic r;
    r = 1'b0;
    for (int i = 0; i < n; i++) r = r | terms[i*w + k];
    return r;
  endfunction

  // Column AND of term bit k in a packed vector of n terms, each w bits wide.
  function automatic logic col_and(input logic [255:0] terms,
                                   input int           n,
                                   input int           w,
                                   input int           k);
    logic r;
    r = 1'b1;
    for (int i = 0; i < n; i++) r = r & terms[i*w + k];
    return r;
  endfunction

endpackage

// File: rtl/la_oapipe_stage.sv
// -----------------------------------------------------------------------------
// la_oapipe_stage
//
// One valid/data pipeline register with load enable.
//
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous, active-high reset (clears valid and data)
//   load      in   stage takes the upstream beat this edge
//   valid_in  in   upstream valid
//   data_in   in   upstream data (W bits)
//   valid_q   out  stage holds a beat
//   data_q    out  stage data (W bits)
//
// Data is written only when the incoming beat is valid, so a bubble passing
// through leaves the data register untouched. This keeps the output stable
// and avoids needless toggling.
// -----------------------------------------------------------------------------
module la_oapipe_stage #(
  parameter int W    = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_q,
  output logic [W-1:0] data_q
);

  // NOTE: the data register is reset along with valid, because z is defined
  // to read 0 straight out of reset and it is a visible port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      // NOTE: non-blocking assignments on every flop, so that all stages
      // update from the pre-edge values of their neighbours.
      valid_q <= valid_in;
      if (valid_in) data_q <= data_in;
    end
  end

endmodule

// File: rtl/la_oapipe.sv
// -----------------------------------------------------------------------------
// la_oapipe
//
// Pipelined, run-time selectable or-and / and-or reduction. For each bit k it
// combines NA a-terms and NB b-terms at that bit:
//   mode 0 OA  : OR(a) & OR(b)      mode 1 OAI : ~OA
//   mode 2 AO  : AND(a) | AND(b)    mode 3 AOI : ~AO
// The result is evaluated combinationally and carried through STAGES
// valid/ready registers. The pipeline collapses bubbles and sustains full
// throughput under backpressure. STAGES = 0 gives a pure combinational path.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   in_valid   in   input beat present
//   in_ready   out  beat accepted this cycle (combinational load chain)
//   mode       in   function select, sampled with the beat
//   a          in   NA*W a-terms, term i at [i*W +: W]
//   b          in   NB*W b-terms, same packing
//   out_valid  out  z holds a result
//   out_ready  in   downstream takes z this cycle
//   z          out  W-bit result
// -----------------------------------------------------------------------------
module la_oapipe
  import la_oapipe_pkg::*;
#(
  parameter int W      = 8,
  parameter int NA     = 3,
  parameter int NB     = 2,
  parameter int STAGES = 2,
  parameter     PROP   = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    mode,
  input  logic [NA*W-1:0] a,
  input  logic [NB*W-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  z
);

  // ---------------------------------------------------------------------------
  // Reduction, evaluated ahead of stage 1. Mode is folded in here, so the
  // stages carry only {valid, result}.
  // ---------------------------------------------------------------------------
  logic [W-1:0] any_a, all_a, any_b, all_b;
  logic [W-1:0] f;

  // NOTE: every always_comb output gets a default before the loops. This
  // keeps the block free of latches whatever NA/NB/W are.
  always_comb begin
    any_a = '0;
    all_a = '1;
    any_b = '0;
    all_b = '1;
    for (int i = 0; i < NA; i++) begin
      any_a = any_a | a[i*W +: W];
      all_a = all_a & a[i*W +: W];
    end
    for (int j = 0; j < NB; j++) begin
      any_b = any_b | b[j*W +: W];
      all_b = all_b & b[j*W +: W];
    end
    f = '0;
    for (int k = 0; k < W; k++) begin
      f[k] = reduce_bit(mode, any_a[k], all_a[k], any_b[k], all_b[k]);
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline or bypass
  // ---------------------------------------------------------------------------
  if (STAGES == 0) begin : g_bypass

    assign z         = f;
    assign out_valid = in_valid;
    assign in_ready  = out_ready;

  end else begin : g_pipe

    logic [STAGES:1] v;
    logic [STAGES:1] load;
    logic [W-1:0]    d [1:STAGES];

    // Load chain, evaluated from the output back. A stage loads when it is
    // empty or its successor loads. An empty stage anywhere therefore keeps
    // everything upstream of it moving, which squeezes out bubbles while the
    // output stalls.
    always_comb begin
      load         = '0;
      load[STAGES] = ~v[STAGES] | out_ready;
      for (int s = STAGES - 1; s >= 1; s--) begin
        load[s] = ~v[s] | load[s+1];
      end
    end

    for (genvar s = 1; s <= STAGES; s++) begin : g_stage
      logic         vin;
      logic [W-1:0] din;

      if (s == 1) begin : g_first
        assign vin = in_valid;
        assign din = f;
      end else begin : g_next
        assign vin = v[s-1];
        assign din = d[s-1];
      end

      la_oapipe_stage #(
        .W    (W),
        .PROP (PROP)
      ) u_stage (
        .clk      (clk),
        .reset    (reset),
        .load     (load[s]),
        .valid_in (vin),
        .data_in  (din),
        .valid_q  (v[s]),
        .data_q   (d[s])
      );
    end

    // in_ready is the stage-1 load condition itself. There is no registered
    // ready, so a full pipeline still moves one beat per cycle when
    // out_ready is high.
    assign in_ready  = load[1];
    assign out_valid = v[STAGES];
    assign z         = d[STAGES];

  end

endmodule

// File: tb/tb_la_oapipe.sv
// -----------------------------------------------------------------------------
// tb_la_oapipe
//
// Bench for la_oapipe (W=8, NA=3, NB=2). It has two instances:
//   dut  : STAGES=2, checked through a scoreboard plus scenario checks
//   dut0 : STAGES=0, checked combinationally
// Inputs change 1 time unit after the rising edge. The monitor samples on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_la_oapipe;

  localparam int W  = 8;
  localparam int NA = 3;
  localparam int NB = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, out_valid, out_ready;
  logic [1:0]      mode;
  logic [NA*W-1:0] a;
  logic [NB*W-1:0] b;
  logic [W-1:0]    z;

  logic            c_in_valid, c_in_ready, c_out_valid, c_out_ready;
  logic [1:0]      c_mode;
  logic [NA*W-1:0] c_a;
  logic [NB*W-1:0] c_b;
  logic [W-1:0]    c_z;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  la_oapipe #(.W(W), .NA(NA), .NB(NB), .STAGES(2), .PROP("DEFAULT")) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .z(z)
  );

  la_oapipe #(.W(W), .NA(NA), .NB(NB), .STAGES(0), .PROP("DEFAULT")) dut0 (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .mode(c_mode), .a(c_a), .b(c_b), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .z(c_z)
  );

  // Reference model, written directly from the per-bit definitions.
  function automatic logic [W-1:0] model(input logic [1:0] m,
                                         input logic [NA*W-1:0] aa,
                                         input logic [NB*W-1:0] bb);
    logic [W-1:0] r;
    logic oa, al, ob, bl;
    r = '0;
    for (int k = 0; k < W; k++) begin
      oa = aa[k] | aa[W+k] | aa[2*W+k];
      al = aa[k] & aa[W+k] & aa[2*W+k];
      ob = bb[k] | bb[W+k];
      bl = bb[k] & bb[W+k];
      case (m)
        2'd0:    r[k] = oa & ob;
        2'd1:    r[k] = ~(oa & ob);
        2'd2:    r[k] = al | bl;
        default: r[k] = ~(al | bl);
      endcase
    end
    return r;
  endfunction

  // Scoreboard monitor: it pushes on input transfer and pops on output
  // transfer. Reset discards everything in flight.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_beat: z=%h with no beat outstanding", z);
        end else begin
          logic [W-1:0] exp_z;
          exp_z = sb.pop_front();
          if (z !== exp_z) begin
            errors++;
            $display("FAIL sb_data: z=%h expected %h", z, exp_z);
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(model(mode, a, b));
    end
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic drive(input logic iv, input logic [1:0] m,
                       input logic [NA*W-1:0] aa, input logic [NB*W-1:0] bb);
    in_valid = iv;
    mode     = m;
    a        = aa;
    b        = bb;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: outstanding=%0d out_valid=%b, expected 0 and 0",
               sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out_valid !== 1'b0 || z !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_during: out_valid=%b z=%h in_ready=%b expected 0 00 1",
               out_valid, z, in_ready);
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_empty: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || z !== 8'h00 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_after: out_valid=%b z=%h in_ready=%b expected 0 00 1",
               out_valid, z, in_ready);
    end
  endtask

  task automatic test_modes();
    logic [1:0]      tm [4];
    logic [NA*W-1:0] ta [4];
    logic [NB*W-1:0] tb [4];
    logic [W-1:0]    te [4];
    tm[0] = 2'd0; ta[0] = 24'h000FF0; tb[0] = 16'h3C00; te[0] = 8'h3C;
    tm[1] = 2'd1; ta[1] = 24'h000FF0; tb[1] = 16'h3C00; te[1] = 8'hC3;
    tm[2] = 2'd2; ta[2] = 24'hFFF03C; tb[2] = 16'h0101; te[2] = 8'h31;
    tm[3] = 2'd3; ta[3] = 24'hFFF03C; tb[3] = 16'h0101; te[3] = 8'hCE;
    out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      drive(1'b1, tm[t], ta[t], tb[t]);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d_lat0: out_valid=%b expected 0", t, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mode%0d_lat1: out_valid=%b expected 0", t, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || z !== te[t]) begin
        errors++;
        $display("FAIL mode%0d_result: out_valid=%b z=%h expected 1 %h",
                 t, out_valid, z, te[t]);
      end
    end
    wait_drain();
  endtask

  task automatic test_stream_stall();
    int ones, rises, accepts;
    logic prev, acc;
    logic [1:0] m;
    logic [NA*W-1:0] aa;
    logic [NB*W-1:0] bb;
    logic [W-1:0] exp0;
    out_ready = 1'b1;
    ones = 0; rises = 0; prev = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      drive(c < 6, 2'($urandom_range(0, 3)), 24'($urandom), 16'($urandom));
      @(negedge clk);
      if (out_valid) begin
        ones++;
        if (!prev) rises++;
      end
      prev = out_valid;
    end
    checks++;
    if (ones != 6 || rises != 1) begin
      errors++;
      $display("FAIL stream_no_gaps: valid_cycles=%0d runs=%0d expected 6 1", ones, rises);
    end
    wait_drain();

    // Stall phase: the output is blocked and beats are offered every cycle.
    accepts = 0; acc = 1'b1; exp0 = '0;
    m = '0; aa = '0; bb = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (acc) begin
        m  = 2'($urandom_range(0, 3));
        aa = 24'($urandom);
        bb = 16'($urandom);
      end
      if (c == 0) exp0 = model(m, aa, bb);
      drive(1'b1, m, aa, bb);
      @(negedge clk);
      acc = in_ready;
      if (in_ready) accepts++;
      if (c >= 2) begin
        checks++;
        if (out_valid !== 1'b1 || z !== exp0) begin
          errors++;
          $display("FAIL stall_hold c%0d: out_valid=%b z=%h expected 1 %h",
                   c, out_valid, z, exp0);
        end
      end
    end
    checks++;
    if (accepts != 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_accepts: accepts=%0d in_ready=%b expected 2 0", accepts, in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_bubble();
    logic [W-1:0] exp_b;
    logic [NA*W-1:0] aa;
    logic [NB*W-1:0] bb;
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2'd0, 24'h0000FF, 16'h00AA);   // beat A -> 8'hAA
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    aa = 24'h123456; bb = 16'h0F0F;
    exp_b = model(2'd2, aa, bb);
    drive(1'b1, 2'd2, aa, bb);                 // beat B
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bubble_ready_open: in_ready=%b expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || z !== 8'hAA) begin
      errors++;
      $display("FAIL bubble_full: in_ready=%b out_valid=%b z=%h expected 0 1 aa",
               in_ready, out_valid, z);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || z !== exp_b) begin
      errors++;
      $display("FAIL bubble_consecutive: out_valid=%b z=%h expected 1 %h",
               out_valid, z, exp_b);
    end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    int leaked;
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, 2'd0, 24'hFFFFFF, 16'hFFFF);
    @(posedge clk); #1;
    drive(1'b1, 2'd3, 24'h0F0F0F, 16'hF0F0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_full: out_valid=%b in_ready=%b expected 1 0", out_valid, in_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || z !== 8'h00) begin
      errors++;
      $display("FAIL rst_mid_async: out_valid=%b z=%h expected 0 00", out_valid, z);
    end
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    leaked = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) leaked++;
    end
    checks++;
    if (leaked != 0) begin
      errors++;
      $display("FAIL rst_mid_leak: valid_cycles=%0d expected 0", leaked);
    end
  endtask

  task automatic test_comb();
    logic [W-1:0] exp_z;
    for (int i = 0; i < 8; i++) begin
      c_mode      = 2'(i);
      c_a         = (i == 0) ? 24'h000FF0 : 24'($urandom);
      c_b         = (i == 0) ? 16'h3C00   : 16'($urandom);
      c_in_valid  = 1'(i ^ (i >> 2));
      c_out_ready = 1'(i >> 1);
      exp_z       = model(c_mode, c_a, c_b);
      #1;
      checks++;
      if (c_z !== exp_z || c_out_valid !== c_in_valid || c_in_ready !== c_out_ready) begin
        errors++;
        $display("FAIL comb%0d: z=%h ov=%b ir=%b expected %h %b %b",
                 i, c_z, c_out_valid, c_in_ready, exp_z, c_in_valid, c_out_ready);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'd0, '0, '0);
    out_ready   = 1'b1;
    c_in_valid  = 1'b0;
    c_out_ready = 1'b0;
    c_mode      = 2'd0;
    c_a         = '0;
    c_b         = '0;
    test_reset();
    test_modes();
    test_stream_stall();
    test_bubble();
    test_reset_mid();
    test_comb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
